btn_conditioner_4ch: RTL and testbench

- Front-end conditioning bank for the four panel push-buttons.
- Sits directly upstream of the multi-function clock top and replaces the per-button edge detectors that feed the mode, watch, stopwatch and cook-timer button inputs.
- Per channel: synchronises the raw pin, debounces it, and produces a level output plus one-cycle press and release pulses.
- Also produces a long-press pulse and an auto-repeat pulse train, used for fast min+/sec+ stepping on the cook timer and watch set mode.

---
 rtl/btn_conditioner_4ch.sv | 163 ++++++++++++++++
 tb/tb_btn_conditioner_4ch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner_4ch.sv
// Four-channel push-button conditioner: 2-flop sync, debounce, press/release/long-press/auto-repeat pulses.
// Latency: btn_level and all pulses change DEBOUNCE_CYCLES+2 edges after the raw pin changes; pulses are registered.
// Backpressure: none; free-running, every pulse is exactly one cycle wide and must be consumed when it appears.
module btn_conditioner_4ch #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_pe,
    output logic [N-1:0] btn_ne,
    output logic [N-1:0] btn_long,
    output logic [N-1:0] btn_rep
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESSED,
        ST_REPEAT
    } state_t;

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    // Two-flop synchroniser for the asynchronous button pins; only sync2_q is used downstream.
    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : ch_g
        logic          level_q, level_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
        state_t        state_q, state_d;
        logic          pe_q, pe_d;
        logic          ne_q, ne_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;
        logic          rise, fall;

        // Debounce: count consecutive cycles the synced pin disagrees with the level; any agreement restarts.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            rise     = 1'b0;
            fall     = 1'b0;
            if (sync2_q[i] != level_q) begin
                if (db_cnt_q == DB_MAX) begin
                    level_d = ~level_q;
                    rise    = ~level_q;
                    fall    = level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Hold FSM: press/release pulses, long-press point, then periodic repeat; release always wins.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            pe_d       = 1'b0;
            ne_d       = 1'b0;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (rise) begin
                        state_d    = ST_PRESSED;
                        pe_d       = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                ST_PRESSED: begin
                    if (fall) begin
                        state_d    = ST_RELEASED;
                        ne_d       = 1'b1;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else if (hold_cnt_q == HOLD_MAX) begin
                        state_d    = ST_REPEAT;
                        long_d     = 1'b1;
                        rep_d      = 1'b1;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (fall) begin
                        state_d    = ST_RELEASED;
                        ne_d       = 1'b1;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else if (rep_cnt_q == REP_MAX) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_RELEASED;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end

        // Per-channel state and registered pulse outputs, all cleared asynchronously.
        always_ff @(posedge clk or negedge reset_p) begin
            if (!reset_p) begin
                level_q    <= 1'b0;
                db_cnt_q   <= '0;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                state_q    <= ST_RELEASED;
                pe_q       <= 1'b0;
                ne_q       <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                level_q    <= level_d;
                db_cnt_q   <= db_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                state_q    <= state_d;
                pe_q       <= pe_d;
                ne_q       <= ne_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pe[i]    = pe_q;
        assign btn_ne[i]    = ne_q;
        assign btn_long[i]  = long_q;
        assign btn_rep[i]   = rep_q;
    end

endmodule

// File: tb/tb_btn_conditioner_4ch.sv
// Testbench for btn_conditioner_4ch with short debounce/hold/repeat periods.
// Directed scenarios with hand-computed edge numbers; outputs sampled 1 time unit after each rising edge.
// Ends with a single summary line.
module tb_btn_conditioner_4ch;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int HLD = 10;
    localparam int RPT = 3;

    logic         clk;
    logic         reset_p;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pe;
    logic [N-1:0] btn_ne;
    logic [N-1:0] btn_long;
    logic [N-1:0] btn_rep;

    int checks = 0;
    int errors = 0;

    btn_conditioner_4ch #(
        .N              (N),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HLD),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pe   (btn_pe),
        .btn_ne   (btn_ne),
        .btn_long (btn_long),
        .btn_rep  (btn_rep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " level"}, btn_level, 0);
        check({tag, " pe"},    btn_pe,    0);
        check({tag, " ne"},    btn_ne,    0);
        check({tag, " long"},  btn_long,  0);
        check({tag, " rep"},   btn_rep,   0);
    endtask

    task automatic do_reset();
        btn_raw = '0;
        reset_p = 1'b0;
        tick();
        tick();
        check_all_zero("in_reset");
        reset_p = 1'b1;
    endtask

    // Raw is already at its new value before the next edge (edge 1); level and pe rise on edge DEB+2.
    task automatic expect_rise(input string tag, input logic [N-1:0] mask);
        for (int k = 1; k <= DEB + 2; k++) begin
            tick();
            check({tag, " rise level"}, btn_level, (k == DEB + 2) ? mask : 4'b0000);
            check({tag, " rise pe"},    btn_pe,    (k == DEB + 2) ? mask : 4'b0000);
        end
    endtask

    // k counts edges after the pe edge; raw for mask is dropped right after edge rel_after.
    task automatic hold_run(input string tag, input logic [N-1:0] mask, input int rel_after, input int n);
        int fall_k;
        fall_k = rel_after + DEB + 2;
        for (int k = 1; k <= n; k++) begin
            tick();
            check({tag, " level"}, btn_level, (k < fall_k) ? mask : 4'b0000);
            check({tag, " pe"},    btn_pe,    0);
            check({tag, " ne"},    btn_ne,    (k == fall_k) ? mask : 4'b0000);
            check({tag, " long"},  btn_long,  (k == HLD && k < fall_k) ? mask : 4'b0000);
            check({tag, " rep"},   btn_rep,
                  (k >= HLD && k < fall_k && ((k - HLD) % RPT) == 0) ? mask : 4'b0000);
            if (k == rel_after) btn_raw = btn_raw & ~mask;
        end
    endtask

    initial begin
        reset_p = 1'b0;
        btn_raw = '0;
        #1;
        check_all_zero("reset_t0");
        tick();
        tick();
        check_all_zero("reset_edge");
        reset_p = 1'b1;

        // Clean press on channel 0, held 8 cycles, then released.
        btn_raw = 4'b0001;
        expect_rise("clean", 4'b0001);
        hold_run("clean_hold", 4'b0001, 2, 10);

        // Bounce on channel 1: 1,0,1,0 then settle high.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            check("bounce level", btn_level, 0);
            check("bounce pe",    btn_pe,    0);
        end
        btn_raw = 4'b0010;
        expect_rise("settle", 4'b0010);
        tick();
        check("settle pe_once", btn_pe, 0);

        // Three-cycle high glitch on channel 0 must not move the level.
        do_reset();
        btn_raw = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("glitch level", btn_level, 0);
            check("glitch pe",    btn_pe,    0);
            if (k == 3) btn_raw = 4'b0000;
        end

        // Long press with repeat train on channel 2, released after 30 cycles.
        do_reset();
        btn_raw = 4'b0100;
        expect_rise("long", 4'b0100);
        hold_run("long_hold", 4'b0100, 30, 40);

        // Release lands on a repeat tick (edge 16 after pe): only ne fires, repeat stops.
        do_reset();
        btn_raw = 4'b0001;
        expect_rise("collide", 4'b0001);
        hold_run("collide_hold", 4'b0001, HLD, 24);

        // Asynchronous reset while channel 3 is repeating, pin kept high.
        do_reset();
        btn_raw = 4'b1000;
        expect_rise("arst", 4'b1000);
        hold_run("arst_hold", 4'b1000, 100, 14);
        #2;
        reset_p = 1'b0;
        #1;
        check_all_zero("arst_async");
        tick();
        check_all_zero("arst_held");
        reset_p = 1'b1;
        expect_rise("arst_again", 4'b1000);
        hold_run("arst_again_hold", 4'b1000, 100, 11);

        // All four channels pressed together, released on consecutive cycles.
        do_reset();
        btn_raw = 4'b1111;
        expect_rise("all", 4'b1111);
        for (int k = 1; k <= 10; k++) begin
            if (k <= 4) btn_raw = 4'(4'b1111 << k);
            tick();
            check("stagger ne",   btn_ne,   (k >= 6 && k <= 9) ? 4'(1 << (k - 6)) : 4'b0000);
            check("stagger long", btn_long, 0);
            check("stagger rep",  btn_rep,  0);
        end
        check("stagger level_end", btn_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
